// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM states and the alignment/legality rule for the LSU.
// Latency: n/a (declarations and a pure combinational function).
// Backpressure: n/a.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  // True when the access can't be issued: unknown size code (stores only
  // know b/h/w) or the address is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo,
                                         input logic       we);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = we;
      F3_H:    bad = addr_lo[0];
      F3_HU:   bad = we | addr_lo[0];
      F3_W:    bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the byte/half lane out of a dmem word and sign- or zero-extends it.
// Latency: combinational.
// Backpressure: none.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rd,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select from the low address bits, then extend by size code.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = mem_rd[7:0];
      2'd1:    byte_sel = mem_rd[15:8];
      2'd2:    byte_sel = mem_rd[23:16];
      default: byte_sel = mem_rd[31:24];
    endcase
    half_sel = addr_lo[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'b0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'b0, half_sel};
      // Word, and unknown codes when no checking is built in: whole word.
      default: data = mem_rd;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store unit: one core request -> one dmem access -> one aligned response.
// Latency: accept->resp_valid 2 cycles for stores, 2+MEM_LAT for loads, 1 for rejected requests.
// Backpressure: one request in flight; req_ready only in IDLE, response held until resp_ready.
// Build option LSU_ALIGN_CHECK_EN: reject misaligned/illegal-funct3 requests with resp_err.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int MEM_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rd
);

  localparam logic [2:0] CNT_INIT = (MEM_LAT > 0) ? 3'(MEM_LAT - 1) : 3'd0;

  lsu_state_e  state;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [2:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        req_bad;
  logic [31:0] ld_data;

`ifdef LSU_ALIGN_CHECK_EN
  assign req_bad = is_misaligned(req_funct3, req_addr[1:0], req_we);
`else
  // Without checking, everything goes to dmem with its low bits intact.
  assign req_bad = 1'b0;
`endif

  lsu_load_align u_align (
    .mem_rd  (mem_rd),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .data    (ld_data)
  );

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  // Decoded from state so reset kills the write strobe without waiting for a clock.
  assign mem_we     = (state == ACCESS) && we_q;
  assign mem_addr   = addr_q;
  assign mem_wd     = wd_q;
  assign mem_funct3 = f3_q;

  // Request capture, access sequencing, read-latency countdown and response hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wd_q    <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            wd_q   <= req_wdata;
            f3_q   <= req_funct3;
            we_q   <= req_we;
            if (req_bad) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              state   <= RESP;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (we_q) begin
            rdata_q <= '0;
            state   <= RESP;
          end else if (MEM_LAT == 0) begin
            rdata_q <= ld_data;
            state   <= RESP;
          end else begin
            cnt_q <= CNT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 3'd0) begin
            rdata_q <= ld_data;
            state   <= RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator with a behavioural dmem and reference model.
// Latency: n/a.
// Backpressure: exercises resp_ready hold-off and reset during an access.
module tb_lsu_mem_initiator;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [2:0]  mem_funct3;

  int errors = 0;
  int checks = 0;

  logic [31:0] dmem    [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [9:0]  dm_idx;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.MEM_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_funct3 (mem_funct3),
    .mem_rd     (mem_rd)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      16:      return 32'h1122_3344;
      20:      return 32'hCAFE_F00D;
      default: return (32'(i) * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endcase
  endfunction

  // Behavioural dmem: combinational read, lane-selected write on the clock edge.
  assign mem_rd = dmem[mem_addr[11:2]];
  initial begin
    for (int i = 0; i < 1024; i++) dmem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_we) begin
        dm_idx = mem_addr[11:2];
        case (mem_funct3)
          3'b000:  dmem[dm_idx][8*mem_addr[1:0] +: 8] = mem_wd[7:0];
          3'b001:  dmem[dm_idx][16*mem_addr[1] +: 16] = mem_wd[15:0];
          default: dmem[dm_idx] = mem_wd;
        endcase
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_ALIGN_CHECK_EN
    int size;
    if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5)) return 1'b1;
    size = 1 << f3[1:0];
    return (int'(addr % 32'd4) % size) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [31:0] addr);
    logic [31:0] v;
    int sh;
    case (f3)
      3'd0, 3'd4: begin
        sh = 8 * int'(addr % 32'd4);
        v  = (word >> sh) & 32'hFF;
        if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        sh = 16 * int'((addr / 32'd2) % 32'd2);
        v  = (word >> sh) & 32'hFFFF;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [2:0] f3,
                                              input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    case (f3)
      3'd0: begin sh = 8 * int'(addr % 32'd4); mask = 32'hFF << sh; end
      3'd1: begin sh = 16 * int'((addr / 32'd2) % 32'd2); mask = 32'hFFFF << sh; end
      default: return wd;
    endcase
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // One full transaction; called and returns at a negedge with the DUT idle.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int hold,
                         input logic [31:0] exp_rd, input logic exp_err);
    int n, wes, exp_lat;
    logic [9:0] idx;
    exp_lat = exp_err ? 1 : (we ? 2 : 2 + LAT);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1; wes = 0;
    if (!exp_err) begin
      chk("mem_addr", mem_addr, addr);
      chk("mem_funct3", 32'(mem_funct3), 32'(f3));
      chk("mem_wd", mem_wd, wd);
    end
    while (!resp_valid && n < 20) begin
      if (mem_we) wes++;
      if (req_ready) chk("req_ready_busy", 32'(req_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("mem_we_pulses", 32'(wes), (we && !exp_err) ? 32'd1 : 32'd0);
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_err", 32'(resp_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, exp_rd);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_mem_we", 32'(mem_we), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid_drop", 32'(resp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
    idx = addr[11:2];
    if (we && !model_err(we, f3, addr)) ref_mem[idx] = model_store(ref_mem[idx], f3, addr, wd);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int hold,
                              input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd; v.hold = hold;
    v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic        r_we, e;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wd, r_exp;
    int          r_hold;

    vecs.push_back(mk(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, 32'h0,          1'b0));
    vecs.push_back(mk(1'b0, 3'b010, 32'h10, 32'h0,         4, 32'hDEAD_BEEF,  1'b0));
    vecs.push_back(mk(1'b1, 3'b010, 32'h20, 32'h80FF_7F01, 0, 32'h0,          1'b0));
    vecs.push_back(mk(1'b0, 3'b000, 32'h23, 32'h0,         0, 32'hFFFF_FF80,  1'b0));
    vecs.push_back(mk(1'b0, 3'b100, 32'h23, 32'h0,         1, 32'h0000_0080,  1'b0));
    vecs.push_back(mk(1'b0, 3'b001, 32'h22, 32'h0,         0, 32'hFFFF_80FF,  1'b0));
    vecs.push_back(mk(1'b0, 3'b101, 32'h20, 32'h0,         0, 32'h0000_7F01,  1'b0));
    vecs.push_back(mk(1'b1, 3'b000, 32'h21, 32'h0000_0012, 0, 32'h0,          1'b0));
    vecs.push_back(mk(1'b0, 3'b010, 32'h20, 32'h0,         0, 32'h80FF_1201,  1'b0));
    vecs.push_back(mk(1'b1, 3'b001, 32'h22, 32'h5555_ABCD, 2, 32'h0,          1'b0));
    vecs.push_back(mk(1'b0, 3'b010, 32'h20, 32'h0,         0, 32'hABCD_1201,  1'b0));
    vecs.push_back(mk(1'b0, 3'b001, 32'h22, 32'h0,         0, 32'hFFFF_ABCD,  1'b0));
`ifdef LSU_ALIGN_CHECK_EN
    vecs.push_back(mk(1'b0, 3'b010, 32'h21, 32'h0,         2, 32'h0,          1'b1));
    vecs.push_back(mk(1'b1, 3'b001, 32'h33, 32'h0000_FFFF, 0, 32'h0,          1'b1));
    vecs.push_back(mk(1'b0, 3'b011, 32'h20, 32'h0,         0, 32'h0,          1'b1));
    vecs.push_back(mk(1'b1, 3'b100, 32'h20, 32'h1111_1111, 0, 32'h0,          1'b1));
    vecs.push_back(mk(1'b0, 3'b010, 32'h20, 32'h0,         0, 32'hABCD_1201,  1'b0));
`else
    vecs.push_back(mk(1'b1, 3'b001, 32'h41, 32'h0000_ABCD, 0, 32'h0,          1'b0));
    vecs.push_back(mk(1'b0, 3'b010, 32'h40, 32'h0,         0, 32'h1122_ABCD,  1'b0));
    vecs.push_back(mk(1'b0, 3'b010, 32'h21, 32'h0,         0, 32'hABCD_1201,  1'b0));
    vecs.push_back(mk(1'b0, 3'b001, 32'h23, 32'h0,         0, 32'hFFFF_ABCD,  1'b0));
    vecs.push_back(mk(1'b0, 3'b011, 32'h20, 32'h0,         0, 32'hABCD_1201,  1'b0));
    vecs.push_back(mk(1'b1, 3'b100, 32'h24, 32'h0102_0304, 0, 32'h0,          1'b0));
    vecs.push_back(mk(1'b0, 3'b010, 32'h24, 32'h0,         0, 32'h0102_0304,  1'b0));
`endif

    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    chk("rst_mem_funct3", 32'(mem_funct3), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[k])
      run_txn(vecs[k].we, vecs[k].f3, vecs[k].addr, vecs[k].wd, vecs[k].hold,
              vecs[k].exp_rd, vecs[k].exp_err);

    // Reset during the store access cycle: the write must never land.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h50; req_wdata = 32'h0BAD_0BAD;
    @(posedge clk);
    #1;
    chk("rstmid_we_before", 32'(mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_we_async", 32'(mem_we), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_req_ready", 32'(req_ready), 32'd1);
    chk("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    chk("rstmid_word", dmem[20], 32'hCAFE_F00D);

    // Random traffic over a small window so stores and loads collide.
    for (int k = 0; k < 150; k++) begin
      r_we   = 1'($urandom_range(1));
      r_f3   = 3'($urandom_range(7));
      r_addr = 32'($urandom_range(63));
      r_wd   = $urandom;
      r_hold = int'($urandom_range(2));
      e      = model_err(r_we, r_f3, r_addr);
      r_exp  = (e || r_we) ? 32'h0 : model_load(ref_mem[r_addr[11:2]], r_f3, r_addr);
      run_txn(r_we, r_f3, r_addr, r_wd, r_hold, r_exp, e);
    end

    for (int i = 0; i < 16; i++) chk($sformatf("final_word_%0d", i), dmem[i], ref_mem[i]);
    chk("final_word_20", dmem[20], ref_mem[20]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
